// File: rtl/pmips_dmem_responder_if.sv
// Data-memory bus between the PMIPS MEM stage (master) and its responder (slave).
// The request fields are driven by the core. Load data comes back combinationally.
interface pmips_dmem_responder_if;
  logic [15:0] dmemaddr;
  logic [15:0] dmemwdata;
  logic        dmemwrite;
  logic        dmemread;
  logic [15:0] dmemrdata;

  modport master (
    output dmemaddr,
    output dmemwdata,
    output dmemwrite,
    output dmemread,
    input  dmemrdata
  );

  modport slave (
    input  dmemaddr,
    input  dmemwdata,
    input  dmemwrite,
    input  dmemread,
    output dmemrdata
  );
endinterface

// File: rtl/pmips_dmem_responder.sv
// PMIPS data-memory responder: word RAM plus a 4-word MMIO page (LED, SW, CNT, STAT).
// Reads are combinational in the request cycle. Writes commit on the posedge.
// Optional feature macro: PMIPS_DMEM_ERRCHK_EN enables the sticky access-error flag.
// Without that macro, the flag is tied to 0 and STAT reads as zero.
module pmips_dmem_responder #(
  parameter int unsigned ADDR_BITS = 8,
  parameter logic [15:0] MMIO_BASE = 16'hFFF0,
  parameter int unsigned SW_WIDTH  = 8,
  parameter int unsigned LED_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  pmips_dmem_responder_if.slave dmem,
  input  logic [SW_WIDTH-1:0]  sw_in,
  output logic [LED_WIDTH-1:0] led_out,
  output logic                 err_out
);

  localparam logic [16:0] RAM_LIMIT = 17'(2 * (2 ** ADDR_BITS));

  localparam logic [1:0] W_LED  = 2'd0;
  localparam logic [1:0] W_SW   = 2'd1;
  localparam logic [1:0] W_CNT  = 2'd2;
  localparam logic [1:0] W_STAT = 2'd3;

  logic [15:0]          ram_q [0:(2**ADDR_BITS)-1];
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [SW_WIDTH-1:0]  sw_s1_q, sw_s2_q;
  logic                 err_flag_s;

  logic                 is_ram_s, is_mmio_s;
  logic [15:0]          mmio_off_s;
  logic [1:0]           mmio_word_s;
  logic [ADDR_BITS-1:0] ram_idx_s;
  logic                 wr_ram_s, wr_led_s, wr_cnt_s;

  // Address decode; RAM wins if a parameterisation ever overlaps the MMIO page.
  always_comb begin
    is_ram_s    = ({1'b0, dmem.dmemaddr} < RAM_LIMIT);
    mmio_off_s  = dmem.dmemaddr - MMIO_BASE;
    is_mmio_s   = !is_ram_s && (dmem.dmemaddr >= MMIO_BASE) && (mmio_off_s < 16'd8);
    mmio_word_s = mmio_off_s[2:1];
    ram_idx_s   = dmem.dmemaddr[ADDR_BITS:1];
    wr_ram_s    = dmem.dmemwrite && is_ram_s;
    wr_led_s    = dmem.dmemwrite && is_mmio_s && (mmio_word_s == W_LED);
    wr_cnt_s    = dmem.dmemwrite && is_mmio_s && (mmio_word_s == W_CNT);
  end

  // Combinational load data: selected word, or zero when idle or unmapped.
  always_comb begin
    dmem.dmemrdata = 16'h0000;
    if (dmem.dmemread && is_ram_s) begin
      dmem.dmemrdata = ram_q[ram_idx_s];
    end else if (dmem.dmemread && is_mmio_s) begin
      case (mmio_word_s)
        W_LED:   dmem.dmemrdata = 16'(led_q);
        W_SW:    dmem.dmemrdata = 16'(sw_s2_q);
        W_CNT:   dmem.dmemrdata = cnt_q;
        W_STAT:  dmem.dmemrdata = {15'd0, err_flag_s};
        default: dmem.dmemrdata = 16'h0000;
      endcase
    end else begin
      dmem.dmemrdata = 16'h0000;
    end
  end

  // Next state for LED and CNT; a CNT store overrides that edge's increment.
  always_comb begin
    led_d = led_q;
    cnt_d = cnt_q + 16'd1;
    if (wr_led_s) begin
      led_d = dmem.dmemwdata[LED_WIDTH-1:0];
    end else begin
      led_d = led_q;
    end
    if (wr_cnt_s) begin
      cnt_d = dmem.dmemwdata;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // MMIO registers and the two-flop switch synchroniser.
  always_ff @(posedge clock) begin
    if (reset) begin
      led_q   <= '0;
      cnt_q   <= 16'h0000;
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      led_q   <= led_d;
      cnt_q   <= cnt_d;
      sw_s1_q <= sw_in;
      sw_s2_q <= sw_s1_q;
    end
  end

  // RAM store port; contents survive reset, but a store during reset is dropped.
  always_ff @(posedge clock) begin
    if (!reset && wr_ram_s) begin
      ram_q[ram_idx_s] <= dmem.dmemwdata;
    end
  end

`ifdef PMIPS_DMEM_ERRCHK_EN
  logic err_q, err_d, err_set_s, wr_stat_clr_s;

  // Sticky error: a bad access sets it, and that set beats a same-cycle STAT clear.
  always_comb begin
    err_set_s     = (dmem.dmemread || dmem.dmemwrite) &&
                    (dmem.dmemaddr[0] || (!is_ram_s && !is_mmio_s));
    wr_stat_clr_s = dmem.dmemwrite && is_mmio_s && (mmio_word_s == W_STAT) &&
                    dmem.dmemwdata[0];
    if (err_set_s) begin
      err_d = 1'b1;
    end else if (wr_stat_clr_s) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Error flag register.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_flag_s = err_q;
`else
  assign err_flag_s = 1'b0;
`endif

  assign led_out = led_q;
  assign err_out = err_flag_s;

endmodule
